// File: rtl/pps_master_gen.sv
// PPS master generator: fires a pulse at each second rollover of the local clock.
// The fire point is moved earlier to cover the output delay and the output register.
module pps_master_gen #(
  parameter int   ClockPeriod_Gen       = 20,
  parameter int   OutputDelay_Gen       = 0,
  parameter logic OutputPolarity_Gen    = 1'b1,
  parameter int   PulseWidthDefault_Gen = 125
) (
  input  logic        SysClk_ClkIn,
  input  logic        SysRst_RstIn,
  input  logic [31:0] ClockTime_Second_DatIn,
  input  logic [31:0] ClockTime_Nanosecond_DatIn,
  input  logic        ClockTime_TimeJump_DatIn,
  input  logic        ClockTime_ValIn,
  input  logic        Enable_EnaIn,
  input  logic [9:0]  PulseWidth_DatIn,
  input  logic        PulseWidth_ValIn,
  output logic        Pps_EvtOut,
  output logic [31:0] PpsTimestamp_Second_DatOut,
  output logic [31:0] PpsTimestamp_Nanosecond_DatOut,
  output logic        PpsTimestamp_ValOut,
  output logic        Err_EvtOut
);

  localparam logic [31:0] threshold     = 32'(1_000_000_000 - OutputDelay_Gen - ClockPeriod_Gen);
  localparam logic [19:0] cyc_last      = 20'(1_000_000 / ClockPeriod_Gen - 1);
  localparam logic [9:0]  width_default = 10'(PulseWidthDefault_Gen);
  localparam logic        pps_active    = OutputPolarity_Gen;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ARMED,
    ST_HIGH
  } state_t;

  state_t      state_reg, state_next;
  logic [19:0] cyc_reg;
  logic [9:0]  ms_reg;
  logic [9:0]  width_active_reg;
  logic [9:0]  width_pending_reg;
  logic        pps_reg;
  logic [31:0] ts_sec_reg;
  logic        ts_val_reg;
  logic        err_reg;

  logic time_ok;
  logic past_threshold;
  logic ms_step;
  logic fire;
  logic pulse_done;
  logic width_ok;

  assign time_ok        = Enable_EnaIn & ClockTime_ValIn;
  assign past_threshold = ClockTime_Nanosecond_DatIn >= threshold;
  assign ms_step        = cyc_reg == cyc_last;
  assign width_ok       = (PulseWidth_DatIn != 10'd0) && (PulseWidth_DatIn <= 10'd999);

  always_comb begin
    state_next = state_reg;
    fire       = 1'b0;
    pulse_done = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (time_ok) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!time_ok) state_next = ST_IDLE;
        else if (!past_threshold) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (!time_ok) begin
          state_next = ST_IDLE;
        end else if (past_threshold) begin
          // A step landing past the threshold skips this second rather than firing late.
          if (ClockTime_TimeJump_DatIn) begin
            state_next = ST_WAIT;
          end else begin
            fire       = 1'b1;
            state_next = ST_HIGH;
          end
        end
      end
      ST_HIGH: begin
        // Last active cycle: the ms counter reaches the width on this step.
        if (ms_step && (ms_reg + 10'd1 == width_active_reg)) begin
          pulse_done = 1'b1;
          state_next = time_ok ? ST_WAIT : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge SysClk_ClkIn) begin
    if (SysRst_RstIn) begin
      state_reg         <= ST_IDLE;
      cyc_reg           <= '0;
      ms_reg            <= '0;
      width_active_reg  <= width_default;
      width_pending_reg <= width_default;
      pps_reg           <= ~pps_active;
      ts_sec_reg        <= '0;
      ts_val_reg        <= 1'b0;
      err_reg           <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ts_val_reg <= fire;
      err_reg    <= PulseWidth_ValIn & ~width_ok;
      if (PulseWidth_ValIn && width_ok) width_pending_reg <= PulseWidth_DatIn;

      if (fire) begin
        pps_reg          <= pps_active;
        ts_sec_reg       <= ClockTime_Second_DatIn + 32'd1;
        width_active_reg <= width_pending_reg;
        cyc_reg          <= '0;
        ms_reg           <= '0;
      end else if (state_reg == ST_HIGH) begin
        if (pulse_done) pps_reg <= ~pps_active;
        if (ms_step) begin
          cyc_reg <= '0;
          ms_reg  <= ms_reg + 10'd1;
        end else begin
          cyc_reg <= cyc_reg + 20'd1;
        end
      end
    end
  end

  assign Pps_EvtOut                     = pps_reg;
  assign PpsTimestamp_Second_DatOut     = ts_sec_reg;
  assign PpsTimestamp_Nanosecond_DatOut = '0;
  assign PpsTimestamp_ValOut            = ts_val_reg;
  assign Err_EvtOut                     = err_reg;

endmodule

// File: tb/tb_pps_master_gen.sv
// Directed bench for pps_master_gen: two fast instances (20 ns period) for edge timing
// and polarity, one slow instance (100 us period) for full pulse widths and the state machine.
module tb_pps_master_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Fast group: instances a (delay 0, active high) and c (delay 100, active low)
  logic        f_rst_a, f_rst_c;
  logic [31:0] f_sec, f_ns;
  logic        f_jump, f_val, f_en;
  logic [9:0]  f_pw;
  logic        f_pw_val;
  logic        a_pps, a_ts_val, a_err, c_pps, c_ts_val, c_err;
  logic [31:0] a_ts_sec, a_ts_ns, c_ts_sec, c_ts_ns;

  // Slow group: instance b, 10 cycles per ms
  localparam logic [31:0] TB = 32'd999_900_000;
  logic        s_rst;
  logic [31:0] s_sec, s_ns;
  logic        s_jump, s_val, s_en;
  logic [9:0]  s_pw;
  logic        s_pw_val;
  logic        b_pps, b_ts_val, b_err;
  logic [31:0] b_ts_sec, b_ts_ns;

  pps_master_gen #(.ClockPeriod_Gen(20), .OutputDelay_Gen(0), .OutputPolarity_Gen(1'b1),
                   .PulseWidthDefault_Gen(125)) dut_a (
    .SysClk_ClkIn(clk), .SysRst_RstIn(f_rst_a),
    .ClockTime_Second_DatIn(f_sec), .ClockTime_Nanosecond_DatIn(f_ns),
    .ClockTime_TimeJump_DatIn(f_jump), .ClockTime_ValIn(f_val), .Enable_EnaIn(f_en),
    .PulseWidth_DatIn(f_pw), .PulseWidth_ValIn(f_pw_val), .Pps_EvtOut(a_pps),
    .PpsTimestamp_Second_DatOut(a_ts_sec), .PpsTimestamp_Nanosecond_DatOut(a_ts_ns),
    .PpsTimestamp_ValOut(a_ts_val), .Err_EvtOut(a_err));

  pps_master_gen #(.ClockPeriod_Gen(20), .OutputDelay_Gen(100), .OutputPolarity_Gen(1'b0),
                   .PulseWidthDefault_Gen(125)) dut_c (
    .SysClk_ClkIn(clk), .SysRst_RstIn(f_rst_c),
    .ClockTime_Second_DatIn(f_sec), .ClockTime_Nanosecond_DatIn(f_ns),
    .ClockTime_TimeJump_DatIn(f_jump), .ClockTime_ValIn(f_val), .Enable_EnaIn(f_en),
    .PulseWidth_DatIn(f_pw), .PulseWidth_ValIn(f_pw_val), .Pps_EvtOut(c_pps),
    .PpsTimestamp_Second_DatOut(c_ts_sec), .PpsTimestamp_Nanosecond_DatOut(c_ts_ns),
    .PpsTimestamp_ValOut(c_ts_val), .Err_EvtOut(c_err));

  pps_master_gen #(.ClockPeriod_Gen(100_000), .OutputDelay_Gen(0), .OutputPolarity_Gen(1'b1),
                   .PulseWidthDefault_Gen(125)) dut_b (
    .SysClk_ClkIn(clk), .SysRst_RstIn(s_rst),
    .ClockTime_Second_DatIn(s_sec), .ClockTime_Nanosecond_DatIn(s_ns),
    .ClockTime_TimeJump_DatIn(s_jump), .ClockTime_ValIn(s_val), .Enable_EnaIn(s_en),
    .PulseWidth_DatIn(s_pw), .PulseWidth_ValIn(s_pw_val), .Pps_EvtOut(b_pps),
    .PpsTimestamp_Second_DatOut(b_ts_sec), .PpsTimestamp_Nanosecond_DatOut(b_ts_ns),
    .PpsTimestamp_ValOut(b_ts_val), .Err_EvtOut(b_err));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Counts active cycles of b's pulse; called right after the fire edge (first active cycle seen).
  task automatic measure_pulse(output int n);
    n = 1;
    for (int i = 0; i < 5000; i++) begin
      tick;
      if (b_pps) n++;
      else break;
    end
  endtask

  task automatic test_reset;
    f_rst_a = 1; f_rst_c = 1; s_rst = 1;
    f_sec = 0; f_ns = 0; f_jump = 0; f_val = 0; f_en = 0; f_pw = 0; f_pw_val = 0;
    s_sec = 0; s_ns = 0; s_jump = 0; s_val = 0; s_en = 0; s_pw = 0; s_pw_val = 0;
    repeat (3) tick;
    checks++; if (a_pps !== 1'b0) begin errors++; $display("FAIL reset_a_pps got %b want 0", a_pps); end
    checks++; if (c_pps !== 1'b1) begin errors++; $display("FAIL reset_c_pps got %b want 1", c_pps); end
    checks++; if (b_pps !== 1'b0) begin errors++; $display("FAIL reset_b_pps got %b want 0", b_pps); end
    checks++; if (b_ts_sec !== 32'd0 || b_ts_ns !== 32'd0) begin errors++;
      $display("FAIL reset_b_ts got %0d.%0d want 0.0", b_ts_sec, b_ts_ns); end
    checks++; if (b_ts_val !== 1'b0 || b_err !== 1'b0) begin errors++;
      $display("FAIL reset_b_strobes got val=%b err=%b want 0 0", b_ts_val, b_err); end
    $display("test_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  int          a_rise, c_fall;
  logic [31:0] a_sec_seen, c_sec_seen;
  logic        a_val_seen, c_val_seen, a_val_after;

  task automatic test_first_edge;
    f_rst_a = 0; f_rst_c = 0; f_en = 1; f_val = 1; f_sec = 32'd41; f_ns = 32'd999_999_000;
    a_rise = -1; c_fall = -1; a_val_after = 1'bx;
    for (int k = 0; k < 70; k++) begin
      tick;
      if (a_rise >= 0 && k == a_rise + 1) a_val_after = a_ts_val;
      if (a_pps === 1'b1 && a_rise < 0) begin a_rise = k; a_sec_seen = a_ts_sec; a_val_seen = a_ts_val; end
      if (c_pps === 1'b0 && c_fall < 0) begin c_fall = k; c_sec_seen = c_ts_sec; c_val_seen = c_ts_val; end
      f_ns = f_ns + 32'd20;
      if (f_ns >= 32'd1_000_000_000) begin f_ns = f_ns - 32'd1_000_000_000; f_sec = f_sec + 32'd1; end
    end
    checks++; if (a_rise != 49) begin errors++; $display("FAIL a_rise_cycle got %0d want 49", a_rise); end
    checks++; if (a_sec_seen !== 32'd42 || a_val_seen !== 1'b1) begin errors++;
      $display("FAIL a_timestamp got sec=%0d val=%b want 42 1", a_sec_seen, a_val_seen); end
    checks++; if (a_val_after !== 1'b0) begin errors++; $display("FAIL a_val_one_cycle got %b want 0", a_val_after); end
    checks++; if (a_pps !== 1'b1 || a_ts_ns !== 32'd0) begin errors++;
      $display("FAIL a_still_active got pps=%b ns=%0d want 1 0", a_pps, a_ts_ns); end
    $display("test_first_edge rise=%0d sec=%0d checks=%0d errors=%0d", a_rise, a_sec_seen, checks, errors);
  endtask

  task automatic test_polarity_reset;
    checks++; if (c_fall != 44) begin errors++; $display("FAIL c_fall_cycle got %0d want 44", c_fall); end
    checks++; if (c_sec_seen !== 32'd42 || c_val_seen !== 1'b1) begin errors++;
      $display("FAIL c_timestamp got sec=%0d val=%b want 42 1", c_sec_seen, c_val_seen); end
    checks++; if (c_pps !== 1'b0) begin errors++; $display("FAIL c_mid_pulse got %b want 0", c_pps); end
    f_rst_c = 1; f_rst_a = 1;
    tick;
    checks++; if (c_pps !== 1'b1) begin errors++; $display("FAIL c_reset_mid_pulse got %b want 1", c_pps); end
    checks++; if (a_pps !== 1'b0) begin errors++; $display("FAIL a_reset_mid_pulse got %b want 0", a_pps); end
    $display("test_polarity_reset fall=%0d checks=%0d errors=%0d", c_fall, checks, errors);
  endtask

  task automatic test_width;
    int n;
    int highs;
    s_rst = 0; s_en = 1; s_val = 1; s_sec = 32'd100; s_ns = 32'd500_000_000;
    tick; tick;
    s_pw = 10'd0; s_pw_val = 1; tick; s_pw_val = 0;
    checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL err_width0 got %b want 1", b_err); end
    tick;
    checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle got %b want 0", b_err); end
    s_pw = 10'd1000; s_pw_val = 1; tick; s_pw_val = 0;
    checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL err_width1000 got %b want 1", b_err); end
    tick;
    s_ns = TB; tick;
    checks++; if (b_pps !== 1'b1 || b_ts_val !== 1'b1 || b_ts_sec !== 32'd101) begin errors++;
      $display("FAIL b_fire1 got pps=%b val=%b sec=%0d want 1 1 101", b_pps, b_ts_val, b_ts_sec); end
    s_ns = 0; s_sec = 32'd101;
    // Measure the 125 ms pulse while requesting 200 ms part-way through.
    n = 1;
    for (int i = 0; i < 5000; i++) begin
      if (n == 500) begin s_pw = 10'd200; s_pw_val = 1; end
      else s_pw_val = 0;
      tick;
      if (b_pps) n++;
      else break;
    end
    s_pw_val = 0;
    checks++; if (n != 1250) begin errors++; $display("FAIL width_default got %0d cycles want 1250", n); end
    checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL err_valid_width got %b want 0", b_err); end
    highs = 0;
    for (int i = 0; i < 50; i++) begin
      s_ns = 32'd500_000_000 + 32'(i) * 32'd10_000_000;
      tick;
      if (b_pps) highs++;
    end
    checks++; if (highs != 0) begin errors++; $display("FAIL no_second_pulse got %0d active cycles want 0", highs); end
    s_ns = 32'd999_950_000; tick;
    checks++; if (b_pps !== 1'b1 || b_ts_sec !== 32'd102) begin errors++;
      $display("FAIL b_fire2 got pps=%b sec=%0d want 1 102", b_pps, b_ts_sec); end
    s_ns = 0; s_sec = 32'd102;
    measure_pulse(n);
    checks++; if (n != 2000) begin errors++; $display("FAIL width_200 got %0d cycles want 2000", n); end
    $display("test_width checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_time_jump;
    int n;
    int highs;
    s_ns = 32'd400_000_000; tick; tick;
    s_ns = TB - 32'd1; tick;
    checks++; if (b_pps !== 1'b0) begin errors++; $display("FAIL below_threshold got %b want 0", b_pps); end
    s_ns = 32'd999_999_990; s_jump = 1; tick;
    s_jump = 0;
    highs = b_pps ? 1 : 0;
    for (int i = 0; i < 5; i++) begin tick; if (b_pps) highs++; end
    checks++; if (highs != 0) begin errors++; $display("FAIL jump_no_pulse got %0d active cycles want 0", highs); end
    s_ns = 0; s_sec = 32'd103; tick; tick;
    s_ns = TB; tick;
    checks++; if (b_pps !== 1'b1 || b_ts_sec !== 32'd104) begin errors++;
      $display("FAIL jump_next_fire got pps=%b sec=%0d want 1 104", b_pps, b_ts_sec); end
    s_ns = 0; s_sec = 32'd104;
    measure_pulse(n);
    checks++; if (n != 2000) begin errors++; $display("FAIL jump_pulse_width got %0d want 2000", n); end
    $display("test_time_jump checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_disable;
    int n;
    int highs;
    tick;
    s_ns = TB; tick;
    checks++; if (b_pps !== 1'b1) begin errors++; $display("FAIL dis_fire got %b want 1", b_pps); end
    s_en = 0; s_val = 0; s_jump = 1; s_ns = 0;
    measure_pulse(n);
    s_jump = 0;
    checks++; if (n != 2000) begin errors++; $display("FAIL dis_full_width got %0d want 2000", n); end
    highs = 0;
    for (int i = 0; i < 10; i++) begin s_ns = (i < 5) ? 32'd0 : TB; tick; if (b_pps) highs++; end
    checks++; if (highs != 0) begin errors++; $display("FAIL dis_idle got %0d active cycles want 0", highs); end
    s_en = 1; s_val = 1; s_ns = 32'd100; tick; tick;
    s_val = 0; s_ns = TB; tick;
    checks++; if (b_pps !== 1'b0) begin errors++; $display("FAIL val_low_armed got %b want 0", b_pps); end
    s_val = 1;
    highs = 0;
    for (int i = 0; i < 5; i++) begin tick; if (b_pps || b_ts_val) highs++; end
    checks++; if (highs != 0) begin errors++; $display("FAIL no_partial_pulse got %0d active cycles want 0", highs); end
    $display("test_disable checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset;
    test_first_edge;
    test_polarity_reset;
    test_width;
    test_time_jump;
    test_disable;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
